// File: rtl/systolic_array_tile_sequencer_pkg.sv
// Shared definitions between the tile sequencer and the array controller:
// state-code width, the codes the controller decodes, and the internal
// sequencer state encoding.
package systolic_array_pkg;

   localparam int unsigned CTRL_WIDTH = 4;

   localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE   = 4'd0;
   localparam logic [CTRL_WIDTH-1:0] CTRL_STEADY = 4'd1;
   localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN  = 4'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEADY,
      S_DRAIN,
      S_GAP
   } seq_state_e;

endpackage

// File: rtl/systolic_array_tile_sequencer_if.sv
// Job/config inputs, datapath drain flags and sequencer outputs bundled
// into one interface. The master side is the job issuer, the slave side
// is the sequencer.
interface systolic_array_tile_sequencer_if #(
   parameter int unsigned NUM_COL    = 8,
   parameter int unsigned L          = 10,
   parameter int unsigned CTRL_WIDTH = systolic_array_pkg::CTRL_WIDTH
);

   logic                  i_start;
   logic [L-1:0]          i_k_len;
   logic [7:0]            i_num_tiles;
   logic [L-1:0]          i_top_base;
   logic [L-1:0]          i_left_base;
   logic [NUM_COL-1:0]    i_sa_valid_down;

   logic [CTRL_WIDTH-1:0] o_ctrl_state;
   logic [L-1:0]          o_top_rd_start_addr;
   logic [L-1:0]          o_top_rd_end_addr;
   logic [L-1:0]          o_left_rd_start_addr;
   logic [L-1:0]          o_left_rd_end_addr;
   logic [7:0]            o_tile_idx;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_err_timeout;

   modport master (
      output i_start, i_k_len, i_num_tiles, i_top_base, i_left_base, i_sa_valid_down,
      input  o_ctrl_state, o_top_rd_start_addr, o_top_rd_end_addr,
             o_left_rd_start_addr, o_left_rd_end_addr, o_tile_idx,
             o_busy, o_done, o_err_timeout
   );

   modport slave (
      input  i_start, i_k_len, i_num_tiles, i_top_base, i_left_base, i_sa_valid_down,
      output o_ctrl_state, o_top_rd_start_addr, o_top_rd_end_addr,
             o_left_rd_start_addr, o_left_rd_end_addr, o_tile_idx,
             o_busy, o_done, o_err_timeout
   );

endinterface

// File: rtl/systolic_array_tile_sequencer.sv
// Tile sequencer for a systolic array: walks a job of num_tiles tiles,
// each tile being a STEADY phase of fixed length, a DRAIN phase waiting for
// NUM_ROW bottom-valid cycles (with timeout), and a one-cycle GAP that lets
// the array controller re-initialise. SRAM read ranges advance by k_len per tile.
module systolic_array_tile_sequencer #(
   parameter int unsigned NUM_ROW              = 8,
   parameter int unsigned NUM_COL              = 8,
   parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
   parameter int unsigned CTRL_WIDTH           = systolic_array_pkg::CTRL_WIDTH,
   parameter int unsigned DRAIN_TIMEOUT        = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   systolic_array_tile_sequencer_if.slave bus
);

   import systolic_array_pkg::*;

   localparam int unsigned L  = LOG2_SRAM_BANK_DEPTH;
   localparam int unsigned CW = L + $clog2(NUM_ROW + NUM_COL) + 1;
   localparam int unsigned DW = $clog2(NUM_ROW + 1);
   localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);

   seq_state_e            state_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  err_q;
   logic [L-1:0]          k_len_q;
   logic [7:0]            num_tiles_q;
   logic [7:0]            tile_idx_q;
   logic [L-1:0]          top_start_q, top_end_q;
   logic [L-1:0]          left_start_q, left_end_q;
   logic [CW-1:0]         cyc_cnt_q;
   logic [DW-1:0]         drain_cnt_q;
   logic [TW-1:0]         to_cnt_q;

   logic                  start_ok;
   logic [CW-1:0]         steady_last;
   logic                  drain_hit;
   logic                  drain_fin;
   logic                  drain_to;
   logic                  last_tile;
   logic [L-1:0]          top_start_d, top_end_d;
   logic [L-1:0]          left_start_d, left_end_d;

   // Transition conditions and next-tile addresses (L-bit, wrapping).
   always_comb begin
      start_ok     = bus.i_start && (bus.i_k_len != '0) && (bus.i_num_tiles != '0);
      steady_last  = CW'(k_len_q) + CW'(NUM_ROW + NUM_COL - 2);
      drain_hit    = bus.i_sa_valid_down[NUM_COL-1];
      drain_fin    = drain_hit && (drain_cnt_q == DW'(NUM_ROW - 1));
      drain_to     = (to_cnt_q == TW'(DRAIN_TIMEOUT - 1));
      last_tile    = (tile_idx_q == (num_tiles_q - 8'd1));
      top_start_d  = top_start_q  + k_len_q;
      top_end_d    = top_end_q    + k_len_q;
      left_start_d = left_start_q + k_len_q;
      left_end_d   = left_end_q   + k_len_q;
   end

   // Sequencer FSM; ctrl/busy/done are registered alongside each transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ctrl_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         k_len_q      <= '0;
         num_tiles_q  <= '0;
         tile_idx_q   <= '0;
         top_start_q  <= '0;
         top_end_q    <= '0;
         left_start_q <= '0;
         left_end_q   <= '0;
         cyc_cnt_q    <= '0;
         drain_cnt_q  <= '0;
         to_cnt_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_ok) begin
                  k_len_q      <= bus.i_k_len;
                  num_tiles_q  <= bus.i_num_tiles;
                  tile_idx_q   <= '0;
                  top_start_q  <= bus.i_top_base;
                  top_end_q    <= bus.i_top_base + bus.i_k_len;
                  left_start_q <= bus.i_left_base;
                  left_end_q   <= bus.i_left_base + bus.i_k_len;
                  err_q        <= 1'b0;
                  cyc_cnt_q    <= '0;
                  state_q      <= S_STEADY;
                  ctrl_q       <= CTRL_WIDTH'(CTRL_STEADY);
                  busy_q       <= 1'b1;
               end else if (bus.i_start) begin
                  done_q <= 1'b1;
               end
            end
            S_STEADY: begin
               if (cyc_cnt_q == steady_last) begin
                  drain_cnt_q <= '0;
                  to_cnt_q    <= '0;
                  state_q     <= S_DRAIN;
                  ctrl_q      <= CTRL_WIDTH'(CTRL_DRAIN);
               end else begin
                  cyc_cnt_q <= cyc_cnt_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (drain_hit) drain_cnt_q <= drain_cnt_q + 1'b1;
               to_cnt_q <= to_cnt_q + 1'b1;
               // Completion wins over a timeout landing on the same cycle.
               if (drain_fin) begin
                  state_q <= S_GAP;
                  ctrl_q  <= CTRL_WIDTH'(CTRL_IDLE);
               end else if (drain_to) begin
                  err_q   <= 1'b1;
                  state_q <= S_GAP;
                  ctrl_q  <= CTRL_WIDTH'(CTRL_IDLE);
               end
            end
            S_GAP: begin
               if (last_tile) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  tile_idx_q   <= tile_idx_q + 8'd1;
                  top_start_q  <= top_start_d;
                  top_end_q    <= top_end_d;
                  left_start_q <= left_start_d;
                  left_end_q   <= left_end_d;
                  cyc_cnt_q    <= '0;
                  state_q      <= S_STEADY;
                  ctrl_q       <= CTRL_WIDTH'(CTRL_STEADY);
               end
            end
            default: begin
               state_q <= S_IDLE;
               ctrl_q  <= CTRL_WIDTH'(CTRL_IDLE);
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ctrl_state         = ctrl_q;
   assign bus.o_top_rd_start_addr  = top_start_q;
   assign bus.o_top_rd_end_addr    = top_end_q;
   assign bus.o_left_rd_start_addr = left_start_q;
   assign bus.o_left_rd_end_addr   = left_end_q;
   assign bus.o_tile_idx           = tile_idx_q;
   assign bus.o_busy               = busy_q;
   assign bus.o_done               = done_q;
   assign bus.o_err_timeout        = err_q;

endmodule

// File: tb/tb_systolic_array_tile_sequencer.sv
// Directed bench for the tile sequencer: a table of jobs with hand-computed
// phase lengths and address ranges, plus hand-written reset, degenerate-start
// and mid-drain reset sequences.
module tb_systolic_array_tile_sequencer;

   logic clk;
   logic rst_n;

   systolic_array_tile_sequencer_if #(.NUM_COL(8), .L(10), .CTRL_WIDTH(4)) bus ();

   systolic_array_tile_sequencer #(
      .NUM_ROW(8),
      .NUM_COL(8),
      .LOG2_SRAM_BANK_DEPTH(10),
      .CTRL_WIDTH(4),
      .DRAIN_TIMEOUT(64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode: 0 = valid every drain cycle, 1 = valid every other cycle, 2 = stall
   typedef struct {
      logic [9:0]  k;
      logic [7:0]  nt;
      logic [9:0]  top;
      logic [9:0]  left;
      int unsigned mode;
      int unsigned exp_steady;
      int unsigned exp_drain;
      logic [9:0]  exp_top_end0;
      logic [9:0]  exp_left_end0;
      logic [9:0]  exp_top_last;
      logic        exp_err;
   } vec_t;

   vec_t vecs[5];
   int   checks;
   int   failures;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic junk_cfg();
      bus.i_k_len     = 10'h055;
      bus.i_num_tiles = 8'd7;
      bus.i_top_base  = 10'h2AA;
      bus.i_left_base = 10'h2AA;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"},  bus.o_ctrl_state, 0);
      chk({tag, "_ts"},    bus.o_top_rd_start_addr, 0);
      chk({tag, "_te"},    bus.o_top_rd_end_addr, 0);
      chk({tag, "_ls"},    bus.o_left_rd_start_addr, 0);
      chk({tag, "_le"},    bus.o_left_rd_end_addr, 0);
      chk({tag, "_tile"},  bus.o_tile_idx, 0);
      chk({tag, "_busy"},  bus.o_busy, 0);
      chk({tag, "_done"},  bus.o_done, 0);
      chk({tag, "_err"},   bus.o_err_timeout, 0);
   endtask

   task automatic run_job(input vec_t v);
      int unsigned n;
      logic [9:0]  tt, ts, te, ls, le;
      logic        stable;
      logic        vb;
      bus.i_k_len     = v.k;
      bus.i_num_tiles = v.nt;
      bus.i_top_base  = v.top;
      bus.i_left_base = v.left;
      bus.i_start     = 1'b1;
      tick();
      bus.i_start = 1'b0;
      junk_cfg();
      chk("err_clear_on_start", bus.o_err_timeout, 0);
      for (int t = 0; t < int'(v.nt); t++) begin
         tt = 10'(t);
         ts = v.top  + tt * v.k;
         te = ts + v.k;
         ls = v.left + tt * v.k;
         le = ls + v.k;
         chk("ctrl_steady", bus.o_ctrl_state, 1);
         chk("busy_steady", bus.o_busy, 1);
         chk("tile_idx",    bus.o_tile_idx, t);
         chk("top_start",   bus.o_top_rd_start_addr, ts);
         chk("top_end",     bus.o_top_rd_end_addr, te);
         chk("left_start",  bus.o_left_rd_start_addr, ls);
         chk("left_end",    bus.o_left_rd_end_addr, le);
         if (t == 0) begin
            chk("top_end_tile0",  bus.o_top_rd_end_addr, v.exp_top_end0);
            chk("left_end_tile0", bus.o_left_rd_end_addr, v.exp_left_end0);
         end
         if (t == int'(v.nt) - 1)
            chk("top_start_last", bus.o_top_rd_start_addr, v.exp_top_last);
         stable = 1'b1;
         n = 0;
         while (bus.o_ctrl_state == 4'd1 && n < 3000) begin
            if (bus.o_top_rd_start_addr != ts || bus.o_top_rd_end_addr != te ||
                bus.o_left_rd_start_addr != ls || bus.o_left_rd_end_addr != le ||
                bus.o_tile_idx != 8'(t))
               stable = 1'b0;
            bus.i_start = (t == 0 && n == 3);
            n++;
            tick();
         end
         bus.i_start = 1'b0;
         chk("steady_len", n, v.exp_steady);
         chk("ctrl_drain", bus.o_ctrl_state, 3);
         n = 0;
         while (bus.o_ctrl_state == 4'd3 && n < 200) begin
            if (bus.o_top_rd_start_addr != ts || bus.o_top_rd_end_addr != te ||
                bus.o_left_rd_start_addr != ls || bus.o_left_rd_end_addr != le ||
                bus.o_tile_idx != 8'(t))
               stable = 1'b0;
            case (v.mode)
               0:       vb = 1'b1;
               1:       vb = n[0];
               default: vb = 1'b0;
            endcase
            bus.i_sa_valid_down = {vb, 7'h7F};
            n++;
            tick();
         end
         bus.i_sa_valid_down = '0;
         chk("drain_len",    n, v.exp_drain);
         chk("addr_stable",  stable, 1);
         chk("ctrl_gap",     bus.o_ctrl_state, 0);
         chk("busy_gap",     bus.o_busy, 1);
         chk("done_gap",     bus.o_done, 0);
         tick();
         if (t == int'(v.nt) - 1) begin
            chk("busy_end",  bus.o_busy, 0);
            chk("done_end",  bus.o_done, 1);
            chk("err_end",   bus.o_err_timeout, v.exp_err);
            tick();
            chk("done_pulse_width", bus.o_done, 0);
         end
      end
   endtask

   initial begin
      int unsigned n;
      checks   = 0;
      failures = 0;
      //          k       nt    top      left     mode steady drain top_end0 left_end0 top_last err
      vecs[0] = '{10'd4,  8'd1, 10'h010, 10'h020, 0,   19,    8,    10'h014, 10'h024,  10'h010, 1'b0};
      vecs[1] = '{10'd8,  8'd3, 10'h000, 10'h000, 0,   23,    8,    10'h008, 10'h008,  10'h010, 1'b0};
      vecs[2] = '{10'd8,  8'd2, 10'h3FC, 10'h100, 1,   23,    16,   10'h004, 10'h108,  10'h004, 1'b0};
      vecs[3] = '{10'd2,  8'd2, 10'h005, 10'h007, 2,   17,    64,   10'h007, 10'h009,  10'h007, 1'b1};
      vecs[4] = '{10'd1,  8'd1, 10'h3FF, 10'h3FF, 0,   16,    8,    10'h000, 10'h000,  10'h3FF, 1'b0};

      rst_n               = 1'b0;
      bus.i_start         = 1'b0;
      bus.i_k_len         = '0;
      bus.i_num_tiles     = '0;
      bus.i_top_base      = '0;
      bus.i_left_base     = '0;
      bus.i_sa_valid_down = '0;
      #3;
      chk_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) run_job(vecs[i]);

      // Zero k_len: done next cycle, no job, addresses keep the last job's values.
      bus.i_k_len = 10'd0; bus.i_num_tiles = 8'd3; bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("degen_k_done", bus.o_done, 1);
      chk("degen_k_busy", bus.o_busy, 0);
      chk("degen_k_ctrl", bus.o_ctrl_state, 0);
      chk("degen_k_ts",   bus.o_top_rd_start_addr, 10'h3FF);
      chk("degen_k_te",   bus.o_top_rd_end_addr, 10'h000);
      chk("degen_k_ls",   bus.o_left_rd_start_addr, 10'h3FF);
      tick();
      chk("degen_k_done_clr", bus.o_done, 0);
      chk("degen_k_busy2",    bus.o_busy, 0);

      // Zero tile count.
      bus.i_k_len = 10'd5; bus.i_num_tiles = 8'd0; bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      chk("degen_nt_done", bus.o_done, 1);
      chk("degen_nt_busy", bus.o_busy, 0);
      chk("degen_nt_te",   bus.o_top_rd_end_addr, 10'h000);
      tick();
      chk("degen_nt_done_clr", bus.o_done, 0);

      // Reset in the middle of DRAIN aborts asynchronously without done.
      bus.i_k_len = 10'd4; bus.i_num_tiles = 8'd1;
      bus.i_top_base = 10'h010; bus.i_left_base = 10'h020;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      n = 0;
      while (bus.o_ctrl_state != 4'd3 && n < 100) begin
         n++;
         tick();
      end
      chk("mid_reached_drain", bus.o_ctrl_state, 3);
      bus.i_sa_valid_down = 8'h80;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      tick();
      chk("mid_rst_done_hold", bus.o_done, 0);
      rst_n = 1'b1;
      bus.i_sa_valid_down = '0;
      tick();
      chk("post_rst_done", bus.o_done, 0);
      chk("post_rst_busy", bus.o_busy, 0);
      run_job(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_array_tile_sequencer.md
SYSTOLIC_ARRAY_TILE_SEQUENCER -- requirements
Module: systolic_array_tile_sequencer

Interface
REQ-001 Parameter NUM_ROW, default 8, array rows; DRAIN completes after this many bottom-valid cycles.
REQ-002 Parameter NUM_COL, default 8, array columns; width of the bottom-valid input.
REQ-003 Parameter LOG2_SRAM_BANK_DEPTH, default 10, SRAM address width (L).
REQ-004 Parameter CTRL_WIDTH, default 4, width of the state code driven to the array controller.
REQ-005 Parameter DRAIN_TIMEOUT, default 64, maximum DRAIN cycles before abort.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 i_start  input  1  one-cycle job start request.
REQ-009 i_k_len  input  L  reduction length per tile, in SRAM rows.
REQ-010 i_num_tiles  input  8  tiles in the job.
REQ-011 i_top_base / i_left_base  input  L each  first-tile start addresses of the top and left SRAMs.
REQ-012 i_sa_valid_down  input  NUM_COL  bottom-row valid flags from the datapath.
REQ-013 o_ctrl_state  output  CTRL_WIDTH  state code to the array controller: IDLE=0, STEADY=1, DRAIN=3.
REQ-014 o_top_rd_start_addr / o_top_rd_end_addr  output  L each  current-tile top read range (end exclusive).
REQ-015 o_left_rd_start_addr / o_left_rd_end_addr  output  L each  current-tile left read range (end exclusive).
REQ-016 o_tile_idx  output  8  index of the tile in progress.
REQ-017 o_busy  output  1  high in every state except S_IDLE.
REQ-018 o_done  output  1  one-cycle pulse at job end.
REQ-019 o_err_timeout  output  1  sticky DRAIN-timeout flag.

Function
REQ-020 Internal states SHALL be S_IDLE, S_STEADY, S_DRAIN and S_GAP; S_IDLE and S_GAP SHALL both drive o_ctrl_state=0, S_STEADY 1, S_DRAIN 3.
REQ-021 In S_IDLE, i_start with i_k_len!=0 and i_num_tiles!=0 SHALL latch k_len, num_tiles and both bases, set tile_idx=0, start=base and end=base+k_len for both SRAMs, clear o_err_timeout, and enter S_STEADY next cycle.
REQ-022 In S_IDLE, i_start with i_k_len==0 or i_num_tiles==0 SHALL pulse o_done the next cycle, leave the state at S_IDLE and leave every address output unchanged.
REQ-023 i_start SHALL be ignored while o_busy=1.
REQ-024 S_STEADY SHALL last exactly k_len+NUM_ROW+NUM_COL-1 cycles, counted by a cycle counter, then go to S_DRAIN.
REQ-025 S_DRAIN SHALL count the cycles with i_sa_valid_down[NUM_COL-1]=1 and go to S_GAP on the cycle after the NUM_ROW-th such cycle.
REQ-026 When S_DRAIN has run DRAIN_TIMEOUT cycles without completing, the block SHALL set o_err_timeout and go to S_GAP.
REQ-027 S_GAP SHALL last exactly one cycle, so that the downstream controller re-initialises its counters.
REQ-028 In S_GAP with tile_idx==num_tiles-1, the block SHALL enter S_IDLE and pulse o_done for one cycle on entry.
REQ-029 In S_GAP otherwise, the block SHALL increment tile_idx, add k_len to all four address outputs, and enter S_STEADY.
REQ-030 Address arithmetic SHALL be L-bit modulo 2^L: sums wrap and carries are discarded.
REQ-031 Address outputs and o_tile_idx SHALL be registered and SHALL remain stable throughout S_STEADY and S_DRAIN.
REQ-032 The config inputs (i_k_len, i_num_tiles, bases) SHALL be sampled only on an accepted i_start; later changes SHALL not affect a running job.

Reset
REQ-033 While rst_n=0, the state SHALL be S_IDLE and all outputs and counters SHALL be 0, including o_err_timeout.
REQ-034 Reset asserted mid-job SHALL abort the job immediately, with no o_done pulse.

Structure
REQ-035 Package systolic_array_pkg SHALL hold CTRL_WIDTH and the IDLE/STEADY/DRAIN codes, shared with the array controller.
REQ-036 The block SHALL be a single module with no sub-modules: one FSM plus cycle, drain and timeout counters.

Verification
REQ-037 Single tile: NUM_ROW=NUM_COL=8, k_len=4, top_base=0x10, left_base=0x20 -> STEADY 19 cycles, ranges [0x10,0x14) and [0x20,0x24), DRAIN ends after 8 valid cycles, o_done pulses once.
REQ-038 Three tiles, k_len=8, bases 0 -> top/left start goes 0, 8, 16 with o_tile_idx 0, 1, 2, and o_ctrl_state reads 0 for exactly one cycle between tiles.
REQ-039 Drain stall: hold i_sa_valid_down low in DRAIN -> after 64 cycles o_err_timeout=1 and the sequence continues; the flag clears on the next accepted start.
REQ-040 Wrap: L=10, top_base=0x3FC, k_len=8 -> o_top_rd_end_addr=0x004 and the second tile starts at 0x004.
REQ-041 Degenerate and overlap: k_len=0 start -> o_done one cycle later, o_busy stays 0; i_start during S_STEADY -> no effect.
REQ-042 Reset mid-DRAIN -> all outputs 0 asynchronously and no o_done; a new start then behaves as in REQ-037.
